rx_lane_controller: RTL and testbench

RX_LANE_CONTROLLER -- requirements
Module: rx_lane_controller

---
 rtl/rx_lane_controller.sv | 198 +++++++++++++++++++
 tb/tb_rx_lane_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_lane_controller.sv
// rx_lane_controller: sync-header block lock, bitslip hunting and descrambler
// lock supervision for one 64b/67b receive lane. Once the lane is up, a
// windowed bad-header monitor forces a relock when the header error rate is
// too high.
module rx_lane_controller #(
    parameter int GOOD_LIMIT   = 64,
    parameter int SLIP_WAIT    = 16,
    parameter int META_TIMEOUT = 1024,
    parameter int WINDOW       = 64,
    parameter int BAD_LIMIT    = 16
) (
    input  logic       USER_CLK,
    input  logic       SYSTEM_RESET,
    input  logic [1:0] HEADER_IN,
    input  logic       HEADER_VALID,
    input  logic       DESCRAMBLER_LOCKED,
    output logic       BITSLIP,
    output logic       DESCRAMBLER_RESET,
    output logic       DESCRAMBLER_PASSTHROUGH,
    output logic       LANE_UP,
    output logic [7:0] RELOCK_COUNT,
    output logic [2:0] STATE_OUT
);

    // The timer is shared by the slip hold-off and the descrambler timeout,
    // so it is sized for the larger of the two terminal counts.
    localparam int TIMER_MAX = (SLIP_WAIT > META_TIMEOUT) ? SLIP_WAIT : META_TIMEOUT;
    localparam int TIMER_W   = (TIMER_MAX > 1)  ? $clog2(TIMER_MAX)  : 1;
    localparam int GOOD_W    = (GOOD_LIMIT > 1) ? $clog2(GOOD_LIMIT) : 1;
    localparam int WIN_W     = (WINDOW > 1)     ? $clog2(WINDOW)     : 1;
    localparam int BAD_W     = (BAD_LIMIT > 1)  ? $clog2(BAD_LIMIT)  : 1;

    localparam logic [GOOD_W-1:0]  GOOD_LAST = GOOD_W'(GOOD_LIMIT - 1);
    localparam logic [TIMER_W-1:0] SLIP_LAST = TIMER_W'(SLIP_WAIT - 1);
    localparam logic [TIMER_W-1:0] META_LAST = TIMER_W'(META_TIMEOUT - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [BAD_W-1:0]   BAD_LAST  = BAD_W'(BAD_LIMIT - 1);

    typedef enum logic [2:0] {
        ST_RESET     = 3'b000,
        ST_HUNT      = 3'b001,
        ST_SLIP_WAIT = 3'b010,
        ST_META_WAIT = 3'b011,
        ST_RUN       = 3'b100
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [GOOD_W-1:0]  good_ctr;
    logic [GOOD_W-1:0]  good_ctr_nxt;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_nxt;
    logic [WIN_W-1:0]   window_ctr;
    logic [WIN_W-1:0]   window_ctr_nxt;
    logic [BAD_W-1:0]   bad_ctr;
    logic [BAD_W-1:0]   bad_ctr_nxt;
    logic               relock_inc;
    logic               bitslip_nxt;
    logic               desc_reset_nxt;
    logic               lane_up_nxt;
    logic [7:0]         relock_nxt;
    logic               hdr_good;
    logic               hdr_bad;

    // Unqualified header words never count as either good or bad.
    assign hdr_good = HEADER_VALID && ((HEADER_IN == 2'b01) || (HEADER_IN == 2'b10));
    assign hdr_bad  = HEADER_VALID && ((HEADER_IN == 2'b00) || (HEADER_IN == 2'b11));

    assign STATE_OUT = state;

    // State, counter and output registers; outputs are loaded from values
    // decoded off next_state so they change on the same edge as the state.
    always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
        if (SYSTEM_RESET) begin
            state                   <= ST_RESET;
            good_ctr                <= '0;
            timer                   <= '0;
            window_ctr              <= '0;
            bad_ctr                 <= '0;
            BITSLIP                 <= 1'b0;
            DESCRAMBLER_RESET       <= 1'b1;
            DESCRAMBLER_PASSTHROUGH <= 1'b1;
            LANE_UP                 <= 1'b0;
            RELOCK_COUNT            <= 8'd0;
        end else begin
            state                   <= next_state;
            good_ctr                <= good_ctr_nxt;
            timer                   <= timer_nxt;
            window_ctr              <= window_ctr_nxt;
            bad_ctr                 <= bad_ctr_nxt;
            BITSLIP                 <= bitslip_nxt;
            DESCRAMBLER_RESET       <= desc_reset_nxt;
            DESCRAMBLER_PASSTHROUGH <= desc_reset_nxt;
            LANE_UP                 <= lane_up_nxt;
            RELOCK_COUNT            <= relock_nxt;
        end
    end

    // Next-state and counter update; the bad-header exit is evaluated first so
    // it wins over any descrambler lock change in the same cycle.
    always_comb begin
        next_state     = state;
        good_ctr_nxt   = good_ctr;
        timer_nxt      = timer;
        window_ctr_nxt = window_ctr;
        bad_ctr_nxt    = bad_ctr;
        relock_inc     = 1'b0;
        case (state)
            ST_RESET: begin
                next_state     = ST_HUNT;
                good_ctr_nxt   = '0;
                timer_nxt      = '0;
                window_ctr_nxt = '0;
                bad_ctr_nxt    = '0;
            end
            ST_HUNT: begin
                if (hdr_good) begin
                    if (good_ctr == GOOD_LAST) begin
                        next_state     = ST_META_WAIT;
                        good_ctr_nxt   = '0;
                        timer_nxt      = '0;
                        window_ctr_nxt = '0;
                        bad_ctr_nxt    = '0;
                    end else begin
                        good_ctr_nxt = good_ctr + 1'b1;
                    end
                end else if (hdr_bad) begin
                    next_state   = ST_SLIP_WAIT;
                    good_ctr_nxt = '0;
                    timer_nxt    = '0;
                end
            end
            ST_SLIP_WAIT: begin
                if (timer == SLIP_LAST) begin
                    next_state   = ST_HUNT;
                    good_ctr_nxt = '0;
                    timer_nxt    = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            ST_META_WAIT, ST_RUN: begin
                if (hdr_bad && (bad_ctr == BAD_LAST)) begin
                    next_state     = ST_HUNT;
                    good_ctr_nxt   = '0;
                    timer_nxt      = '0;
                    window_ctr_nxt = '0;
                    bad_ctr_nxt    = '0;
                    relock_inc     = 1'b1;
                end else begin
                    if (HEADER_VALID) begin
                        if (window_ctr == WIN_LAST) begin
                            window_ctr_nxt = '0;
                            bad_ctr_nxt    = '0;
                        end else begin
                            window_ctr_nxt = window_ctr + 1'b1;
                            if (hdr_bad) begin
                                bad_ctr_nxt = bad_ctr + 1'b1;
                            end
                        end
                    end
                    if (state == ST_META_WAIT) begin
                        if (DESCRAMBLER_LOCKED) begin
                            next_state = ST_RUN;
                            timer_nxt  = '0;
                        end else if (timer == META_LAST) begin
                            next_state   = ST_HUNT;
                            good_ctr_nxt = '0;
                            timer_nxt    = '0;
                            relock_inc   = 1'b1;
                        end else begin
                            timer_nxt = timer + 1'b1;
                        end
                    end else if (!DESCRAMBLER_LOCKED) begin
                        next_state = ST_META_WAIT;
                        timer_nxt  = '0;
                    end
                end
            end
            default: begin
                next_state = ST_RESET;
            end
        endcase
    end

    // Output decode from the state being entered; relock count saturates.
    always_comb begin
        bitslip_nxt    = (state == ST_HUNT) && (next_state == ST_SLIP_WAIT);
        desc_reset_nxt = (next_state == ST_RESET) || (next_state == ST_HUNT) ||
                         (next_state == ST_SLIP_WAIT);
        lane_up_nxt    = (next_state == ST_RUN);
        relock_nxt     = RELOCK_COUNT;
        if (relock_inc && (RELOCK_COUNT != 8'hFF)) begin
            relock_nxt = RELOCK_COUNT + 8'd1;
        end
    end

endmodule

// File: tb/tb_rx_lane_controller.sv
// tb_rx_lane_controller: vector table plus hand sequences for the lane
// controller; expected outputs go through a scoreboard queue and are compared
// one cycle after the stimulus that produced them.
module tb_rx_lane_controller;

    localparam logic [2:0] S_RESET = 3'b000;
    localparam logic [2:0] S_HUNT  = 3'b001;
    localparam logic [2:0] S_SLIP  = 3'b010;
    localparam logic [2:0] S_META  = 3'b011;
    localparam logic [2:0] S_RUN   = 3'b100;

    logic       USER_CLK = 1'b0;
    logic       SYSTEM_RESET;
    logic [1:0] HEADER_IN;
    logic       HEADER_VALID;
    logic       DESCRAMBLER_LOCKED;
    logic       BITSLIP;
    logic       DESCRAMBLER_RESET;
    logic       DESCRAMBLER_PASSTHROUGH;
    logic       LANE_UP;
    logic [7:0] RELOCK_COUNT;
    logic [2:0] STATE_OUT;

    typedef struct {
        logic [2:0] state;
        logic       bitslip;
        logic [7:0] relock;
        string      name;
    } exp_t;

    typedef struct {
        logic [1:0] hdr;
        logic       vld;
        logic       lck;
        logic [2:0] state;
        logic       bitslip;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   errors     = 0;
    int   checks     = 0;
    int   exp_relock = 0;

    rx_lane_controller dut (
        .USER_CLK                (USER_CLK),
        .SYSTEM_RESET            (SYSTEM_RESET),
        .HEADER_IN               (HEADER_IN),
        .HEADER_VALID            (HEADER_VALID),
        .DESCRAMBLER_LOCKED      (DESCRAMBLER_LOCKED),
        .BITSLIP                 (BITSLIP),
        .DESCRAMBLER_RESET       (DESCRAMBLER_RESET),
        .DESCRAMBLER_PASSTHROUGH (DESCRAMBLER_PASSTHROUGH),
        .LANE_UP                 (LANE_UP),
        .RELOCK_COUNT            (RELOCK_COUNT),
        .STATE_OUT               (STATE_OUT)
    );

    // Free-running 100 MHz user clock.
    always #5 USER_CLK = ~USER_CLK;

    // Hard stop in case the run wedges.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [1:0] goodHdr(input int i);
        return (i % 2 == 1) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] badHdr(input int i);
        return (i % 2 == 1) ? 2'b00 : 2'b11;
    endfunction

    task automatic pushExpect(input logic [2:0] es, input logic eb, input string nm);
        sb.push_back('{state: es, bitslip: eb, relock: exp_relock[7:0], name: nm});
    endtask

    task automatic checkOutput();
        exp_t e;
        logic dres;
        logic lane;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty: got nothing to compare, required one entry");
            return;
        end
        e    = sb.pop_front();
        dres = (e.state == S_RESET) || (e.state == S_HUNT) || (e.state == S_SLIP);
        lane = (e.state == S_RUN);
        if (STATE_OUT !== e.state || BITSLIP !== e.bitslip || DESCRAMBLER_RESET !== dres ||
            DESCRAMBLER_PASSTHROUGH !== dres || LANE_UP !== lane || RELOCK_COUNT !== e.relock) begin
            errors++;
            $display("[TB] FAIL %s: got state=%b bitslip=%b dres=%b dpass=%b lane=%b relock=%0d, required state=%b bitslip=%b dres=%b dpass=%b lane=%b relock=%0d",
                     e.name, STATE_OUT, BITSLIP, DESCRAMBLER_RESET, DESCRAMBLER_PASSTHROUGH, LANE_UP,
                     RELOCK_COUNT, e.state, e.bitslip, dres, dres, lane, e.relock);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] hdr, input logic vld, input logic lck,
                                 input logic [2:0] es, input logic eb, input bit chk, input string nm);
        @(negedge USER_CLK);
        HEADER_IN          = hdr;
        HEADER_VALID       = vld;
        DESCRAMBLER_LOCKED = lck;
        if (chk) pushExpect(es, eb, nm);
        @(posedge USER_CLK);
        #1;
        if (chk) checkOutput();
    endtask

    task automatic acquireLock(input string tag);
        for (int i = 0; i < 63; i++) applyStimulus(goodHdr(i), 1'b1, 1'b0, S_HUNT, 1'b0, i == 62, {tag, "_hunt"});
        applyStimulus(2'b01, 1'b1, 1'b0, S_META, 1'b0, 1'b1, {tag, "_meta_entry"});
    endtask

    initial begin
        SYSTEM_RESET       = 1'b1;
        HEADER_IN          = 2'b00;
        HEADER_VALID       = 1'b0;
        DESCRAMBLER_LOCKED = 1'b0;

        // Vector table for the initial lock acquisition.
        vecs.push_back('{2'b00, 1'b0, 1'b0, S_HUNT, 1'b0});
        for (int i = 0; i < 5; i++)  vecs.push_back('{2'b11, 1'b0, 1'b0, S_HUNT, 1'b0});
        for (int i = 0; i < 63; i++) vecs.push_back('{goodHdr(i), 1'b1, 1'b0, S_HUNT, 1'b0});
        vecs.push_back('{2'b01, 1'b1, 1'b0, S_META, 1'b0});
        vecs.push_back('{2'b00, 1'b0, 1'b1, S_RUN, 1'b0});
        for (int i = 0; i < 3; i++)  vecs.push_back('{2'b00, 1'b0, 1'b1, S_RUN, 1'b0});

        #3;
        pushExpect(S_RESET, 1'b0, "reset_async");
        checkOutput();
        @(posedge USER_CLK);
        #1;
        pushExpect(S_RESET, 1'b0, "reset_held");
        checkOutput();
        SYSTEM_RESET = 1'b0;

        // Lock acquisition from the table: META_WAIT on the 64th good header,
        // RUN one edge after the descrambler reports lock.
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].hdr, vecs[i].vld, vecs[i].lck, vecs[i].state, vecs[i].bitslip,
                          1'b1, $sformatf("lock_vec%0d", i));
        end

        // Lock loss in RUN then relock within the timeout.
        applyStimulus(2'b00, 1'b0, 1'b0, S_META, 1'b0, 1'b1, "drop_to_meta");
        for (int i = 0; i < 5; i++) applyStimulus(2'b00, 1'b0, 1'b0, S_META, 1'b0, 1'b1, "meta_waiting");
        applyStimulus(2'b00, 1'b0, 1'b1, S_RUN, 1'b0, 1'b1, "relock_run");

        // Descrambler timeout: HUNT exactly 1024 edges after META_WAIT entry.
        applyStimulus(2'b00, 1'b0, 1'b0, S_META, 1'b0, 1'b1, "timeout_entry");
        for (int i = 1; i < 1024; i++) applyStimulus(2'b00, 1'b0, 1'b0, S_META, 1'b0, i == 1023, "timeout_last_meta");
        exp_relock++;
        applyStimulus(2'b00, 1'b0, 1'b0, S_HUNT, 1'b0, 1'b1, "timeout_hunt");

        acquireLock("relock2");
        applyStimulus(2'b00, 1'b0, 1'b1, S_RUN, 1'b0, 1'b1, "relock2_run");

        // Fifteen bad headers per 64-word window in three placements holds RUN.
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 64; i++) begin
                bit is_bad;
                is_bad = (w == 0) ? (i < 15) : (w == 1) ? (i >= 49) : ((i % 4 == 0) && (i < 60));
                applyStimulus(is_bad ? badHdr(i) : goodHdr(i), 1'b1, 1'b1, S_RUN, 1'b0, 1'b1,
                              $sformatf("window%0d_word%0d", w, i));
            end
        end

        // Sixteenth bad header in a window exits to HUNT even with lock dropping.
        for (int k = 0; k < 15; k++) begin
            applyStimulus(badHdr(k), 1'b1, 1'b1, S_RUN, 1'b0, 1'b1, "bad_run_hold");
            applyStimulus(goodHdr(k), 1'b1, 1'b1, S_RUN, 1'b0, 1'b1, "bad_run_good");
        end
        exp_relock++;
        applyStimulus(2'b11, 1'b1, 1'b0, S_HUNT, 1'b0, 1'b1, "bad16_priority_hunt");

        // Bitslip after 30 good headers, 16 cycles of SLIP_WAIT, then a full
        // 64-header count proves good_ctr restarted.
        for (int i = 0; i < 30; i++) applyStimulus(goodHdr(i), 1'b1, 1'b0, S_HUNT, 1'b0, 1'b1, "hunt_30");
        applyStimulus(2'b11, 1'b1, 1'b0, S_SLIP, 1'b1, 1'b1, "slip_pulse");
        for (int i = 1; i < 16; i++) begin
            applyStimulus((i % 3 == 0) ? goodHdr(i) : badHdr(i), 1'b1, 1'b0, S_SLIP, 1'b0, 1'b1,
                          $sformatf("slip_hold%0d", i));
        end
        applyStimulus(2'b00, 1'b0, 1'b0, S_HUNT, 1'b0, 1'b1, "slip_done_hunt");
        for (int i = 0; i < 63; i++) applyStimulus(goodHdr(i), 1'b1, 1'b0, S_HUNT, 1'b0, 1'b1, "post_slip_count");
        applyStimulus(2'b10, 1'b1, 1'b0, S_META, 1'b0, 1'b1, "post_slip_meta");

        // 300 forced lock losses via bad headers in META_WAIT; count saturates.
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 15; k++) applyStimulus(badHdr(k), 1'b1, 1'b0, S_META, 1'b0, 1'b0, "");
            if (exp_relock < 255) exp_relock++;
            applyStimulus(2'b00, 1'b1, 1'b0, S_HUNT, 1'b0, 1'b1, $sformatf("loss%0d", n));
            acquireLock($sformatf("loss%0d", n));
        end

        // Reset asserted while the bitslip pulse is out, mid-SLIP_WAIT.
        for (int k = 0; k < 15; k++) applyStimulus(badHdr(k), 1'b1, 1'b0, S_META, 1'b0, 1'b0, "");
        applyStimulus(2'b11, 1'b1, 1'b0, S_HUNT, 1'b0, 1'b1, "sat_hold_hunt");
        applyStimulus(2'b00, 1'b1, 1'b0, S_SLIP, 1'b1, 1'b1, "pre_reset_slip");
        #1;
        SYSTEM_RESET = 1'b1;
        #1;
        exp_relock = 0;
        pushExpect(S_RESET, 1'b0, "midslip_async_reset");
        checkOutput();
        @(posedge USER_CLK);
        #1;
        pushExpect(S_RESET, 1'b0, "midslip_reset_held");
        checkOutput();
        SYSTEM_RESET = 1'b0;
        applyStimulus(2'b00, 1'b0, 1'b0, S_HUNT, 1'b0, 1'b1, "reset_exit_hunt");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
